// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: predictor, redirect and fetch-queue signals of the fetch PC generator
interface fetch_pc_gen_if #(parameter int W_A = 19);
    logic [W_A-1:0] fetch_pc, btb_target, ras_addr, ex_target, out_pc, out_pred_target;
    logic bp_pred, btb_exist, btb_ras, ras_pop, ex_redirect, out_valid, out_ready, out_pred_taken;
    modport master(
        output fetch_pc, ras_pop, out_valid, out_pc, out_pred_taken, out_pred_target,
        input bp_pred, btb_exist, btb_target, btb_ras, ras_addr, ex_redirect, ex_target, out_ready
    );
    modport slave(
        input fetch_pc, ras_pop, out_valid, out_pc, out_pred_taken, out_pred_target,
        output bp_pred, btb_exist, btb_target, btb_ras, ras_addr, ex_redirect, ex_target, out_ready
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC selection with one-cycle predictor stage (S1) feeding a small fetch queue
module fetch_pc_gen #(
    parameter int W_A      = 19,
    parameter int RESET_PC = 0,
    parameter int FQ_DEPTH = 4,
    parameter int W_FQ     = 2
) (
    input logic           CLK,
    input logic           RST_X,
    input logic           EN,
    fetch_pc_gen_if.master bus
);
    logic [W_A-1:0] pc_q, pc_d, s1_pc, target;
    logic s1_valid, s1_valid_d, taken, acc, deq, full, empty;
    logic [W_A-1:0] q_pc [FQ_DEPTH];
    logic [W_A-1:0] q_tg [FQ_DEPTH];
    logic           q_tk [FQ_DEPTH];
    logic [W_FQ-1:0] wptr, rptr;
    logic [W_FQ:0]   count;

    assign full  = count == (W_FQ+1)'(FQ_DEPTH);
    assign empty = count == '0;
    assign bus.fetch_pc        = pc_q;
    assign bus.out_valid       = EN && !empty;
    assign bus.out_pc          = empty ? '0 : q_pc[rptr];
    assign bus.out_pred_taken  = !empty && q_tk[rptr];
    assign bus.out_pred_target = empty ? '0 : q_tg[rptr];
    assign deq    = bus.out_valid && bus.out_ready;
    assign taken  = bus.btb_exist && (bus.btb_ras || bus.bp_pred);
    assign target = bus.btb_ras ? bus.ras_addr : bus.btb_target;
    assign acc    = EN && s1_valid && !bus.ex_redirect && (!full || deq);
    assign bus.ras_pop = acc && taken && bus.btb_ras;

    // Replay and taken redirects squash the sequential fetch already in flight
    always_comb begin
        pc_d = bus.ex_redirect ? bus.ex_target :
               (s1_valid && !acc) ? s1_pc :
               (acc && taken) ? target : pc_q + W_A'(4);
        s1_valid_d = !bus.ex_redirect && !(s1_valid && !acc) && !(acc && taken);
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            pc_q     <= W_A'(RESET_PC);
            s1_pc    <= '0;
            s1_valid <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else if (EN) begin
            pc_q     <= pc_d;
            s1_pc    <= pc_q;
            s1_valid <= s1_valid_d;
            if (bus.ex_redirect) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                wptr  <= wptr + W_FQ'(acc);
                rptr  <= rptr + W_FQ'(deq);
                count <= count + (W_FQ+1)'(acc) - (W_FQ+1)'(deq);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (acc) begin
            q_pc[wptr] <= s1_pc;
            q_tk[wptr] <= taken;
            q_tg[wptr] <= taken ? target : '0;
        end
    end
endmodule
